// File: rtl/peak_stream_fifo.sv
// peak_stream_fifo
// Captures each new frame of PEAKS peak records from the spectral peak finder
// into a small frame FIFO and serialises them as one peak per beat on a
// valid/ready stream. Frames are detected in the clk domain by watching the
// frame counter become stable and different from the last captured value.
//
// Ports:
//   clk, reset        CLOCK_50 and asynchronous active-high reset
//   amplitudes_in     PEAKS x AMPL_W per-bin peak amplitudes (signed)
//   freqs_in          PEAKS x FREQ_W per-bin frequency bin indices
//   counter_in        frame time, increments once per frame
//   out_valid/ready   stream handshake
//   out_amp/freq/time beat payload (amplitude, frequency bin, frame time)
//   out_bin           peak slot 0..PEAKS-1 of the beat
//   out_last          last emitted beat of the frame
//   overflow          sticky, a frame was dropped because the FIFO was full
//   drop_count        saturating count of dropped frames
//   ovf_clear         synchronous clear of overflow and drop_count
module peak_stream_fifo #(
  parameter int unsigned PEAKS      = 6,
  parameter int unsigned AMPL_W     = 16,
  parameter int unsigned FREQ_W     = 8,
  parameter int unsigned TIME_W     = 16,
  parameter int unsigned DEPTH      = 4,
  parameter bit          DROP_EMPTY = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PEAKS-1:0][AMPL_W-1:0]   amplitudes_in,
  input  logic [PEAKS-1:0][FREQ_W-1:0]   freqs_in,
  input  logic [TIME_W-1:0]              counter_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [AMPL_W-1:0]       out_amp,
  output logic [FREQ_W-1:0]              out_freq,
  output logic [TIME_W-1:0]              out_time,
  output logic [2:0]                     out_bin,
  output logic                           out_last,
  output logic                           overflow,
  output logic [7:0]                     drop_count,
  input  logic                           ovf_clear
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned BIN_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [PEAKS-1:0][AMPL_W-1:0] amp;
    logic [PEAKS-1:0][FREQ_W-1:0] freq;
    logic [TIME_W-1:0]            tstamp;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } state_t;

  // Bits of m strictly above position k.
  function automatic logic [PEAKS-1:0] above_mask(input logic [PEAKS-1:0] m,
                                                  input logic [BIN_W-1:0] k);
    logic [PEAKS-1:0] r;
    r = '0;
    for (int i = 0; i < PEAKS; i++) begin
      if (m[i] && (i > int'(k))) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Index of the lowest set bit of m (0 when m is empty).
  function automatic logic [BIN_W-1:0] low_bit(input logic [PEAKS-1:0] m);
    logic [BIN_W-1:0] r;
    r = '0;
    for (int i = PEAKS - 1; i >= 0; i--) begin
      if (m[i]) r = BIN_W'(i);
    end
    return r;
  endfunction

  // Synchroniser / stability stages and frame tracking
  rec_t                 s1_q, s1_d;
  rec_t                 s2_q, s2_d;
  logic [TIME_W-1:0]    last_time_q, last_time_d;

  // Frame FIFO
  rec_t                 mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

  // Serialiser
  state_t               state_q, state_d;
  logic [PEAKS-1:0][AMPL_W-1:0] sh_amp_q, sh_amp_d;
  logic [PEAKS-1:0][FREQ_W-1:0] sh_freq_q, sh_freq_d;
  logic [TIME_W-1:0]    sh_time_q, sh_time_d;
  logic [PEAKS-1:0]     mask_q, mask_d;

  // Registered outputs
  logic                 out_valid_q, out_valid_d;
  logic [AMPL_W-1:0]    out_amp_q, out_amp_d;
  logic [FREQ_W-1:0]    out_freq_q, out_freq_d;
  logic [TIME_W-1:0]    out_time_q, out_time_d;
  logic [BIN_W-1:0]     out_bin_q, out_bin_d;
  logic                 out_last_q, out_last_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     drop_count_q, drop_count_d;

  // Combinational helpers
  logic                 capture_c;
  logic                 empty_c;
  logic                 full_c;
  logic                 pop_c;
  logic                 wr_en_c;
  logic                 drop_c;
  rec_t                 head_c;
  logic [PEAKS-1:0]     head_mask_c;
  logic [BIN_W-1:0]     first_bin_c;
  logic [BIN_W-1:0]     next_bin_c;
  logic                 ovf_base_c;
  logic [CNT_W-1:0]     drop_base_c;

  // Frame detect, FIFO status and overflow bookkeeping
  always_comb begin
    s1_d        = '{amp: amplitudes_in, freq: freqs_in, tstamp: counter_in};
    s2_d        = s1_q;
    last_time_d = last_time_q;

    // A frame is taken once its counter has been seen unchanged on two
    // consecutive stages, which filters single-cycle counter glitches.
    capture_c = (s2_q.tstamp != last_time_q) && (s1_q.tstamp == s2_q.tstamp);
    if (capture_c) last_time_d = s2_q.tstamp;

    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
              (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    // The LOAD pop frees a slot in the same cycle, so a capture then fits.
    pop_c   = (state_q == ST_LOAD);
    wr_en_c = capture_c && (!full_c || pop_c);
    drop_c  = capture_c && full_c && !pop_c;

    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);

    // Clear is applied first so a simultaneous drop still registers.
    ovf_base_c  = ovf_clear ? 1'b0 : overflow_q;
    drop_base_c = ovf_clear ? '0 : drop_count_q;
    if (drop_c) begin
      overflow_d   = 1'b1;
      drop_count_d = (drop_base_c == 8'hFF) ? drop_base_c : drop_base_c + 8'd1;
    end else begin
      overflow_d   = ovf_base_c;
      drop_count_d = drop_base_c;
    end
  end

  // Head record and its emit mask
  always_comb begin
    head_c = mem_q[rd_ptr_q[IDX_W-1:0]];
    for (int k = 0; k < PEAKS; k++) begin
      head_mask_c[k] = !DROP_EMPTY || (head_c.amp[k] != '0);
    end
    first_bin_c = low_bit(head_mask_c);
    next_bin_c  = low_bit(above_mask(mask_q, out_bin_q));
  end

  // Serialiser next-state and registered outputs
  always_comb begin
    state_d     = state_q;
    sh_amp_d    = sh_amp_q;
    sh_freq_d   = sh_freq_q;
    sh_time_d   = sh_time_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_amp_d   = out_amp_q;
    out_freq_d  = out_freq_q;
    out_time_d  = out_time_q;
    out_bin_d   = out_bin_q;
    out_last_d  = out_last_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty_c) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        sh_amp_d  = head_c.amp;
        sh_freq_d = head_c.freq;
        sh_time_d = head_c.tstamp;
        mask_d    = head_mask_c;
        if (head_mask_c == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_SEND;
          out_valid_d = 1'b1;
          out_bin_d   = first_bin_c;
          out_amp_d   = head_c.amp[first_bin_c];
          out_freq_d  = head_c.freq[first_bin_c];
          out_time_d  = head_c.tstamp;
          out_last_d  = (above_mask(head_mask_c, first_bin_c) == '0);
        end
      end

      ST_SEND: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = empty_c ? ST_IDLE : ST_LOAD;
          end else begin
            out_bin_d  = next_bin_c;
            out_amp_d  = sh_amp_q[next_bin_c];
            out_freq_d = sh_freq_q[next_bin_c];
            out_last_d = (above_mask(mask_q, next_bin_c) == '0);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      last_time_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_IDLE;
      sh_amp_q     <= '0;
      sh_freq_q    <= '0;
      sh_time_q    <= '0;
      mask_q       <= '0;
      out_valid_q  <= 1'b0;
      out_amp_q    <= '0;
      out_freq_q   <= '0;
      out_time_q   <= '0;
      out_bin_q    <= '0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      last_time_q  <= last_time_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      sh_amp_q     <= sh_amp_d;
      sh_freq_q    <= sh_freq_d;
      sh_time_q    <= sh_time_d;
      mask_q       <= mask_d;
      out_valid_q  <= out_valid_d;
      out_amp_q    <= out_amp_d;
      out_freq_q   <= out_freq_d;
      out_time_q   <= out_time_d;
      out_bin_q    <= out_bin_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Frame storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[IDX_W-1:0]] <= s2_q;
  end

  assign out_valid  = out_valid_q;
  assign out_amp    = out_amp_q;
  assign out_freq   = out_freq_q;
  assign out_time   = out_time_q;
  assign out_bin    = out_bin_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_peak_stream_fifo.sv
// Directed bench for peak_stream_fifo: a table of single frames with
// hand-computed beats, plus sequences for backpressure, overflow, counter
// glitches and mid-frame reset. A second instance with DROP_EMPTY = 0 shares
// the inputs and always accepts beats.
module tb_peak_stream_fifo;

  typedef struct packed {
    logic [15:0] amp;
    logic [7:0]  freq;
    logic [15:0] t;
    logic [2:0]  bin;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0]      t;
    logic [5:0][15:0] amp;
    logic [5:0][7:0]  frq;
    logic [5:0]       mask;
    int               nb;
    int               lastb;
  } vec_t;

  logic                   clk;
  logic                   reset;
  logic [5:0][15:0]       amplitudes_in;
  logic [5:0][7:0]        freqs_in;
  logic [15:0]            counter_in;
  logic                   out_valid, out_ready, out_last, overflow, ovf_clear;
  logic signed [15:0]     out_amp;
  logic [7:0]             out_freq, drop_count;
  logic [15:0]            out_time;
  logic [2:0]             out_bin;
  logic                   v0, last0, ovf0, rdy0;
  logic signed [15:0]     amp0;
  logic [7:0]             freq0, dc0;
  logic [15:0]            time0;
  logic [2:0]             bin0;

  int n_cmp;
  int n_fail;

  beat_t mon_q[$];
  beat_t mon0_q[$];
  vec_t  vecs[5];

  peak_stream_fifo dut (
    .clk(clk), .reset(reset), .amplitudes_in(amplitudes_in), .freqs_in(freqs_in),
    .counter_in(counter_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_amp(out_amp), .out_freq(out_freq), .out_time(out_time), .out_bin(out_bin),
    .out_last(out_last), .overflow(overflow), .drop_count(drop_count),
    .ovf_clear(ovf_clear)
  );

  peak_stream_fifo #(.DROP_EMPTY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .amplitudes_in(amplitudes_in), .freqs_in(freqs_in),
    .counter_in(counter_in), .out_valid(v0), .out_ready(rdy0),
    .out_amp(amp0), .out_freq(freq0), .out_time(time0), .out_bin(bin0),
    .out_last(last0), .overflow(ovf0), .drop_count(dc0), .ovf_clear(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted beats; inputs change just after posedge, so negedge sees
  // the handshake that the coming posedge will complete.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (out_valid && out_ready) begin
      b.amp = out_amp; b.freq = out_freq; b.t = out_time; b.bin = out_bin; b.last = out_last;
      mon_q.push_back(b);
    end
    if (v0 && rdy0) begin
      b.amp = amp0; b.freq = freq0; b.t = time0; b.bin = bin0; b.last = last0;
      mon0_q.push_back(b);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input string name, input int idx, input logic [15:0] a,
                          input logic [7:0] f, input logic [15:0] t,
                          input logic [2:0] bn, input logic lst);
    beat_t e;
    e.amp = a; e.freq = f; e.t = t; e.bin = bn; e.last = lst;
    if (idx >= mon_q.size()) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: beat %0d missing, got %0d beats", name, idx, mon_q.size());
    end else begin
      chk(name, 64'(mon_q[idx]), 64'(e));
    end
  endtask

  task automatic set_frame(input logic [15:0] t, input logic [5:0][15:0] a,
                           input logic [5:0][7:0] f);
    counter_in    = t;
    amplitudes_in = a;
    freqs_in      = f;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0][15:0] a_ex;
    logic [5:0][7:0]  f_ex;
    logic [5:0][15:0] a_seq;
    logic [5:0][7:0]  f_seq;
    int first, idx, got, bad;

    n_cmp = 0;
    n_fail = 0;
    a_ex  = {16'd9, 16'd0, 16'd0, 16'd7, 16'd0, 16'd5};
    f_ex  = {8'd120, 8'd90, 8'd60, 8'd40, 8'd20, 8'd3};
    a_seq = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    f_seq = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};

    // bin k of each packed vector is written last-to-first (MSB = bin 5)
    vecs[0] = '{t: 16'd1, amp: a_ex, frq: f_ex, mask: 6'b100101, nb: 3, lastb: 5};
    vecs[1] = '{t: 16'd2, amp: '0, frq: f_ex, mask: 6'b000000, nb: 0, lastb: 0};
    vecs[2] = '{t: 16'd3, amp: {16'h0, 16'hFFFC, 16'h0, 16'h0, 16'h0, 16'h0},
                frq: f_seq, mask: 6'b010000, nb: 1, lastb: 4};
    vecs[3] = '{t: 16'd4, amp: a_seq, frq: f_seq, mask: 6'b111111, nb: 6, lastb: 5};
    vecs[4] = '{t: 16'd5, amp: {16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF},
                frq: {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, mask: 6'b100001, nb: 2, lastb: 5};

    reset = 1'b1;
    out_ready = 1'b1;
    rdy0 = 1'b1;
    ovf_clear = 1'b0;
    set_frame(16'd0, '0, '0);
    cycles(3);
    reset = 1'b0;
    cycles(4);

    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_count", 64'(drop_count), 64'd0);
    chk("reset_payload", 64'({out_amp, out_freq, out_time, out_bin, out_last}), 64'd0);

    // Table of single frames with out_ready held high
    for (int v = 0; v < 5; v++) begin
      mon_q.delete();
      mon0_q.delete();
      set_frame(vecs[v].t, vecs[v].amp, vecs[v].frq);
      first = 0;
      for (int c = 1; c <= 12; c++) begin
        cycles(1);
        if (out_valid && first == 0) first = c;
      end
      cycles(20);
      chk($sformatf("vec%0d_latency", v), 64'(first), (vecs[v].nb == 0) ? 64'd0 : 64'd5);
      chk($sformatf("vec%0d_beats", v), 64'(mon_q.size()), 64'(vecs[v].nb));
      idx = 0;
      for (int k = 0; k < 6; k++) begin
        if (vecs[v].mask[k]) begin
          exp_beat($sformatf("vec%0d_beat%0d", v, idx), idx, vecs[v].amp[k], vecs[v].frq[k],
                   vecs[v].t, 3'(k), (k == vecs[v].lastb));
          idx++;
        end
      end
      chk($sformatf("vec%0d_overflow", v), 64'(overflow), 64'd0);
      if (v == 1) begin
        // Keep-empty instance emits every slot of the all-zero frame
        chk("zero_keep_beats", 64'(mon0_q.size()), 64'd6);
        bad = 0;
        foreach (mon0_q[i]) begin
          if (mon0_q[i].amp != 16'd0 || mon0_q[i].bin != 3'(i) || mon0_q[i].t != 16'd2 ||
              mon0_q[i].last != (i == 5)) bad++;
        end
        chk("zero_keep_content", 64'(bad), 64'd0);
      end
    end

    // Backpressure: first beat held for 10 cycles, then full sequence
    mon_q.delete();
    out_ready = 1'b0;
    set_frame(16'd6, a_ex, f_ex);
    got = 0;
    for (int c = 0; c < 15 && !got; c++) begin
      cycles(1);
      if (out_valid) got = 1;
    end
    chk("bp_first_valid", 64'(got), 64'd1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      cycles(1);
      if (!(out_valid && out_amp == 16'sd5 && out_bin == 3'd0 && out_freq == 8'd3 &&
            out_time == 16'd6 && !out_last)) bad++;
    end
    chk("bp_hold_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    cycles(10);
    chk("bp_beats", 64'(mon_q.size()), 64'd3);
    exp_beat("bp_beat0", 0, 16'd5, 8'd3, 16'd6, 3'd0, 1'b0);
    exp_beat("bp_beat1", 1, 16'd7, 8'd40, 16'd6, 3'd2, 1'b0);
    exp_beat("bp_beat2", 2, 16'd9, 8'd120, 16'd6, 3'd5, 1'b1);

    // Overflow: frame 1 parks in the serialiser, frames 2..5 fill the FIFO
    mon_q.delete();
    out_ready = 1'b0;
    for (int f = 1; f <= 7; f++) begin
      set_frame(16'(6 + f), {80'd0, 16'(f * 10)}, '0);
      cycles(4);
      if (f == 5) chk("ovf_before_drop", 64'({overflow, drop_count}), 64'd0);
      if (f == 6) chk("ovf_first_drop", 64'({overflow, drop_count}), {55'd0, 1'b1, 8'd1});
      if (f == 7) chk("ovf_second_drop", 64'({overflow, drop_count}), {55'd0, 1'b1, 8'd2});
    end
    // Clear coincident with another drop: the drop is counted after the clear
    set_frame(16'd14, {80'd0, 16'd80}, '0);
    cycles(2);
    ovf_clear = 1'b1;
    cycles(1);
    ovf_clear = 1'b0;
    chk("ovf_clear_with_drop", 64'({overflow, drop_count}), {55'd0, 1'b1, 8'd1});
    cycles(2);
    ovf_clear = 1'b1;
    cycles(1);
    ovf_clear = 1'b0;
    chk("ovf_clear", 64'({overflow, drop_count}), 64'd0);
    out_ready = 1'b1;
    cycles(20);
    chk("ovf_beats", 64'(mon_q.size()), 64'd5);
    for (int f = 1; f <= 5; f++) begin
      exp_beat($sformatf("ovf_frame%0d", f), f - 1, 16'(f * 10), 8'd0, 16'(6 + f), 3'd0, 1'b1);
    end

    // Stability: 4 is present for a single cycle only
    set_frame(16'd3, '0, '0);
    cycles(8);
    mon_q.delete();
    set_frame(16'd4, {80'd0, 16'd44}, '0);
    cycles(1);
    set_frame(16'd5, {80'd0, 16'd55}, '0);
    cycles(15);
    chk("glitch_beats", 64'(mon_q.size()), 64'd1);
    exp_beat("glitch_beat", 0, 16'd55, 8'd0, 16'd5, 3'd0, 1'b1);

    // Async reset while bin 2 is on the stream
    set_frame(16'd6, a_ex, f_ex);
    got = 0;
    for (int c = 0; c < 15 && !got; c++) begin
      cycles(1);
      if (out_valid && out_bin == 3'd2) got = 1;
    end
    chk("rst_reach_bin2", 64'(got), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_valid_immediate", 64'(out_valid), 64'd0);
    set_frame(16'd0, a_seq, f_seq);
    cycles(2);
    reset = 1'b0;
    mon_q.delete();
    cycles(10);
    chk("rst_no_stale_beats", 64'(mon_q.size()), 64'd0);
    set_frame(16'd9, a_seq, f_seq);
    cycles(25);
    chk("rst_fresh_beats", 64'(mon_q.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      exp_beat($sformatf("rst_fresh%0d", k), k, a_seq[k], f_seq[k], 16'd9, 3'(k), (k == 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
